// File: rtl/halflife_pkg.sv
// halflife_pkg: shared state type and default sizing for the half-life decay timer
package halflife_pkg;
  typedef enum logic [1:0] {IDLE, DOWN, UP, DONE} state_t;
  localparam int WIDTH_DEF = 8;
  localparam int PRESCALE_DEF = 1;
endpackage

// File: rtl/halflife_prescaler.sv
// halflife_prescaler: step tick every PRESCALE enabled cycles; ports clk, rst, en (count), clr (restart), tick
module halflife_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  logic [PW-1:0] cnt;
  assign tick = en && cnt == PW'(PRESCALE - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr || tick) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
endmodule

// File: rtl/halflife_decay_timer.sv
// halflife_decay_timer: up/decay counter pulsing out at each halving of the load value; ports clk, rst, up, down, load, in -> out, count, halvings, done, busy
module halflife_decay_timer
  import halflife_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int PRESCALE = PRESCALE_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         up,
  input  logic                         down,
  input  logic                         load,
  input  logic [WIDTH-1:0]             in,
  output logic                         out,
  output logic [WIDTH-1:0]             count,
  output logic [$clog2(WIDTH+2)-1:0]   halvings,
  output logic                         done,
  output logic                         busy
);
  state_t state, state_nx;
  logic [WIDTH-1:0] thresh, dec;
  logic thr_valid, act, zero_dn, tick, dtick, utick, hit, fin;
  // a down request at count 0 finishes at once without consuming a tick
  assign act = !load && state != DONE && (up ^ down);
  assign zero_dn = act && down && count == '0;
  assign dtick = tick && down;
  assign utick = tick && up;
  assign dec = count - 1'b1;
  assign hit = dtick && thr_valid && dec == thresh;
  assign fin = zero_dn || (dtick && dec == '0);
  halflife_prescaler #(.PRESCALE(PRESCALE)) u_pre (
    .clk(clk),
    .rst(rst),
    .en(act && !zero_dn),
    .clr(load),
    .tick(tick)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = load ? IDLE : state == DONE ? DONE : fin ? DONE : !(up ^ down) ? IDLE : down ? DOWN : UP;
  always_comb
    busy = state == DOWN || state == UP;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {count, thresh, thr_valid, halvings, out, done} <= '0;
    end else if (load) begin
      count <= in;
      thresh <= in >> 1;
      thr_valid <= 1'b1;
      halvings <= '0;
      out <= 1'b0;
      done <= 1'b0;
    end else begin
      out <= hit;
      if (fin) done <= 1'b1;
      if (dtick) count <= dec;
      else if (utick && count != '1) count <= count + 1'b1;
      if (hit) begin
        thresh <= thresh >> 1;
        thr_valid <= thresh != '0;
        if (halvings != '1) halvings <= halvings + 1'b1;
      end
    end
endmodule
